booth_radix4_seq_mult: RTL and testbench



---
 rtl/booth_radix4_seq_mult_if.sv | 25 ++
 rtl/booth_radix4_seq_mult.sv | 135 +++++++++++++
 tb/tb_booth_radix4_seq_mult.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/booth_radix4_seq_mult_if.sv
// Operand/result handshake bundle for booth_radix4_seq_mult.
// master = issue side, slave = multiplier side.
interface booth_radix4_seq_mult_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, mcand, mplier, is_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, mcand, mplier, is_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Iterative radix-4 Booth multiplier, PP_PER_CYCLE digits retired per cycle.
// Optional BOOTH_EARLY_TERM_EN: leave CALC once all remaining digits are zero.
module booth_radix4_seq_mult #(
  parameter int WIDTH        = 32,
  parameter int PP_PER_CYCLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  booth_radix4_seq_mult_if.slave  io_mul
);
  localparam int NDIG   = WIDTH/2 + 1;
  localparam int N_ITER = (NDIG + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int ACC_W  = 2*WIDTH + 4;
  localparam int EXT_W  = WIDTH + 2;
  localparam int WIN_W  = EXT_W + 1 + 2*PP_PER_CYCLE;
  localparam int CNT_W  = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [EXT_W-1:0]   r_mplier;
  logic               r_lookback;
  logic [ACC_W-1:0]   r_mcand;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_mcandExt;
  logic               w_mplierExt;
  logic [WIN_W-1:0]   w_window;
  logic [EXT_W-1:0]   w_mplierNext;
  logic               w_lookbackNext;
  logic [ACC_W-1:0]   w_accNext;
  logic [ACC_W-1:0]   w_pp;
  logic [2:0]         w_digit;
  logic               w_lastIter;
  logic               w_earlyDone;
  logic               w_calcDone;

  assign w_accept    = io_mul.in_valid && (r_state == ST_IDLE);
  assign w_mcandExt  = io_mul.is_signed & io_mul.mcand[WIDTH-1];
  assign w_mplierExt = io_mul.is_signed & io_mul.mplier[WIDTH-1];

  // The window is the multiplier sign-extended far enough that every digit of
  // this cycle has three valid bits; its upper part is the shifted multiplier.
  assign w_window       = {{(2*PP_PER_CYCLE){r_mplier[EXT_W-1]}}, r_mplier, r_lookback};
  assign w_mplierNext   = w_window[WIN_W-1 -: EXT_W];
  assign w_lookbackNext = w_window[2*PP_PER_CYCLE];

  always_comb begin
    w_accNext = r_acc;
    w_pp      = '0;
    w_digit   = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      w_digit = w_window[2*j +: 3];
      case (w_digit)
        3'b001, 3'b010: w_pp = r_mcand << (2*j);
        3'b011:         w_pp = r_mcand << (2*j + 1);
        3'b100:         w_pp = ~(r_mcand << (2*j + 1)) + ACC_W'(1);
        3'b101, 3'b110: w_pp = ~(r_mcand << (2*j)) + ACC_W'(1);
        default:        w_pp = '0;
      endcase
      // Padding digits past the top of the operand are masked in the last pass.
      if ((int'(r_cnt) * PP_PER_CYCLE + j) < NDIG) begin
        w_accNext = w_accNext + w_pp;
      end
    end
  end

  assign w_lastIter = (r_cnt == LAST_CNT);

`ifdef BOOTH_EARLY_TERM_EN
  logic [EXT_W:0] w_tail;
  assign w_tail      = {w_mplierNext, w_lookbackNext};
  assign w_earlyDone = (~|w_tail) | (&w_tail);
`else
  assign w_earlyDone = 1'b0;
`endif

  assign w_calcDone = w_lastIter | w_earlyDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)         w_stateNext = ST_CALC;
      ST_CALC: if (w_calcDone)       w_stateNext = ST_DONE;
      ST_DONE: if (io_mul.out_ready) w_stateNext = ST_IDLE;
      default:                       w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mplier   <= '0;
      r_lookback <= 1'b0;
      r_mcand    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_product  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_mplier   <= {{2{w_mplierExt}}, io_mul.mplier};
        r_mcand    <= {{(ACC_W-WIDTH){w_mcandExt}}, io_mul.mcand};
        r_lookback <= 1'b0;
        r_acc      <= '0;
        r_cnt      <= '0;
      end
    end else if (r_state == ST_CALC) begin
      r_acc      <= w_accNext;
      r_mplier   <= w_mplierNext;
      r_lookback <= w_lookbackNext;
      r_mcand    <= r_mcand << (2*PP_PER_CYCLE);
      r_cnt      <= r_cnt + CNT_W'(1);
      if (w_calcDone) begin
        r_product <= w_accNext[2*WIDTH-1:0];
      end
    end
  end

  assign io_mul.in_ready  = (r_state == ST_IDLE);
  assign io_mul.out_valid = (r_state == ST_DONE);
  assign io_mul.busy      = (r_state != ST_IDLE);
  assign io_mul.product   = r_product;
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed-vector bench for booth_radix4_seq_mult (32-bit default build)
// plus a WIDTH=8 sweep over PP_PER_CYCLE = 1, 3, 5 against a product model.
module tb_booth_radix4_seq_mult;
`ifdef BOOTH_EARLY_TERM_EN
  localparam int EXP_LAT_SMALL = 1;
`else
  localparam int EXP_LAT_SMALL = 9;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;
  int   lat;

  always #5 clk = ~clk;

  booth_radix4_seq_mult_if #(.WIDTH(32)) mulIf ();
  booth_radix4_seq_mult_if #(.WIDTH(8))  if8p1 ();
  booth_radix4_seq_mult_if #(.WIDTH(8))  if8p3 ();
  booth_radix4_seq_mult_if #(.WIDTH(8))  if8p5 ();

  booth_radix4_seq_mult #(.WIDTH(32), .PP_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .io_mul(mulIf)
  );
  booth_radix4_seq_mult #(.WIDTH(8), .PP_PER_CYCLE(1)) dut8p1 (
    .clk(clk), .rst_n(rst_n), .io_mul(if8p1)
  );
  booth_radix4_seq_mult #(.WIDTH(8), .PP_PER_CYCLE(3)) dut8p3 (
    .clk(clk), .rst_n(rst_n), .io_mul(if8p3)
  );
  booth_radix4_seq_mult #(.WIDTH(8), .PP_PER_CYCLE(5)) dut8p5 (
    .clk(clk), .rst_n(rst_n), .io_mul(if8p5)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operand pair, then waits for out_valid; lat counts edges after accept.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic sgn,
                               output int latency);
    checkOutput({tag, "_in_ready"}, 64'(mulIf.in_ready), 64'd1);
    mulIf.mcand     = a;
    mulIf.mplier    = b;
    mulIf.is_signed = sgn;
    mulIf.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    mulIf.in_valid = 1'b0;
    latency = 0;
    while (!mulIf.out_valid && latency < 40) begin
      @(posedge clk);
      #1;
      latency++;
    end
    if (!mulIf.out_valid) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [63:0] expected);
    int l;
    applyStimulus(tag, a, b, sgn, l);
    checkOutput({tag, "_product"}, mulIf.product, expected);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, 64'(mulIf.out_valid), 64'd0);
  endtask

  task automatic sweepOne(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    logic [15:0] expv;
    int          waitCycles;
    if (sgn) expv = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    else     expv = {8'd0, a} * {8'd0, b};
    if8p1.mcand = a; if8p1.mplier = b; if8p1.is_signed = sgn; if8p1.in_valid = 1'b1;
    if8p3.mcand = a; if8p3.mplier = b; if8p3.is_signed = sgn; if8p3.in_valid = 1'b1;
    if8p5.mcand = a; if8p5.mplier = b; if8p5.is_signed = sgn; if8p5.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if8p1.in_valid = 1'b0; if8p3.in_valid = 1'b0; if8p5.in_valid = 1'b0;
    waitCycles = 0;
    while (!(if8p1.out_valid && if8p3.out_valid && if8p5.out_valid) && waitCycles < 20) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (waitCycles >= 20) checkOutput("sweep_timeout", 64'd0, 64'd1);
    checkOutput("sweep_pp1", 64'(if8p1.product), 64'(expv));
    checkOutput("sweep_pp3", 64'(if8p3.product), 64'(expv));
    checkOutput("sweep_pp5", 64'(if8p5.product), 64'(expv));
    if8p1.out_ready = 1'b1; if8p3.out_ready = 1'b1; if8p5.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if8p1.out_ready = 1'b0; if8p3.out_ready = 1'b0; if8p5.out_ready = 1'b0;
  endtask

  initial begin
    mulIf.in_valid = 1'b0; mulIf.mcand = '0; mulIf.mplier = '0;
    mulIf.is_signed = 1'b0; mulIf.out_ready = 1'b1;
    if8p1.in_valid = 1'b0; if8p1.mcand = '0; if8p1.mplier = '0; if8p1.is_signed = 1'b0; if8p1.out_ready = 1'b0;
    if8p3.in_valid = 1'b0; if8p3.mcand = '0; if8p3.mplier = '0; if8p3.is_signed = 1'b0; if8p3.out_ready = 1'b0;
    if8p5.in_valid = 1'b0; if8p5.mcand = '0; if8p5.mplier = '0; if8p5.is_signed = 1'b0; if8p5.out_ready = 1'b0;

    #3;
    checkOutput("rst_product",   mulIf.product, 64'd0);
    checkOutput("rst_out_valid", 64'(mulIf.out_valid), 64'd0);
    checkOutput("rst_busy",      64'(mulIf.busy), 64'd0);
    checkOutput("rst_in_ready",  64'(mulIf.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] signed -3 * 7");
    applyStimulus("t1", 32'hFFFF_FFFD, 32'd7, 1'b1, lat);
    checkOutput("t1_product", mulIf.product, 64'hFFFF_FFFF_FFFF_FFEB);
    checkOutput("t1_latency", 64'(lat), 64'(EXP_LAT_SMALL));
    checkOutput("t1_busy_done", 64'(mulIf.busy), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("t1_valid_one_cycle", 64'(mulIf.out_valid), 64'd0);
    checkOutput("t1_in_ready_back",   64'(mulIf.in_ready), 64'd1);

    $display("[TB] signed/unsigned all-ones and most-negative operands");
    runOp("t2u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    runOp("t2s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    runOp("t3s", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    runOp("t3u", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    runOp("t3mix", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000);

    $display("[TB] backpressure on result");
    mulIf.out_ready = 1'b0;
    applyStimulus("t4", 32'd5, 32'd9, 1'b0, lat);
    checkOutput("t4_product", mulIf.product, 64'd45);
    for (int k = 0; k < 5; k++) begin
      mulIf.in_valid = (k % 2 == 0);
      mulIf.mcand    = 32'd7;
      mulIf.mplier   = 32'd7;
      @(posedge clk);
      #1;
      checkOutput("t4_hold_valid",   64'(mulIf.out_valid), 64'd1);
      checkOutput("t4_hold_product", mulIf.product, 64'd45);
      checkOutput("t4_hold_in_ready", 64'(mulIf.in_ready), 64'd0);
    end
    mulIf.in_valid  = 1'b0;
    mulIf.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_release_valid",    64'(mulIf.out_valid), 64'd0);
    checkOutput("t4_release_in_ready", 64'(mulIf.in_ready), 64'd1);
    checkOutput("t4_release_busy",     64'(mulIf.busy), 64'd0);
    checkOutput("t4_product_kept",     mulIf.product, 64'd45);

    $display("[TB] reset during CALC");
    mulIf.mcand = 32'h1234; mulIf.mplier = 32'h5678; mulIf.is_signed = 1'b0;
    mulIf.in_valid = 1'b1;
    @(posedge clk);
    #1;
    mulIf.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_busy_before", 64'(mulIf.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_out_valid", 64'(mulIf.out_valid), 64'd0);
    checkOutput("t5_in_ready",  64'(mulIf.in_ready), 64'd1);
    checkOutput("t5_busy",      64'(mulIf.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    runOp("t5_next", 32'd12, 32'd12, 1'b0, 64'd144);

    $display("[TB] multiplier of one");
    applyStimulus("t6", 32'h1234_5678, 32'd1, 1'b0, lat);
    checkOutput("t6_product", mulIf.product, 64'h0000_0000_1234_5678);
    checkOutput("t6_latency", 64'(lat), 64'(EXP_LAT_SMALL));
    @(posedge clk);
    #1;

    $display("[TB] WIDTH=8 sweep");
    sweepOne(8'h80, 8'h80, 1'b1);
    sweepOne(8'hFF, 8'hFF, 1'b0);
    sweepOne(8'hFF, 8'h7F, 1'b1);
    for (int n = 0; n < 12; n++) begin
      sweepOne(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
